ff_ram_mp: RTL and testbench

- Parametrised multi-port flip-flop RAM, successor to the single read/write plus single read SoC scratch RAM.
- Serves NUM_PORTS independent OBI slave ports. Any port can be made writable. Read latency is configurable.
- Every transaction returns rvalid with a per-port error. Lets the core's instruction and data buses, plus a debug or DMA port, share one small FF memory.
- Sits behind the SoC bus mux, in the same address window scheme as the existing SRAM.

---
 rtl/ff_ram_mp.sv | 135 +++++++++++++
 tb/tb_ff_ram_mp.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_ram_mp.sv
// Multi-port flip-flop RAM with OBI slave ports and configurable read latency.
// Optional power-up clearing sweep: define FF_RAM_INIT_CLEAR_EN.
module ff_ram_mp #(
    parameter logic [31:0]          SRAM_BASE_ADDR = 32'h8000_0000,
    parameter int unsigned          SRAM_SIZE      = 64,
    parameter int unsigned          NUM_PORTS      = 2,
    parameter logic [NUM_PORTS-1:0] PORT_WE_MASK   = 'b01,
    parameter int unsigned          READ_LATENCY   = 1,
    parameter int unsigned          ADDR_WIDTH     = $clog2(SRAM_SIZE/4)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_PORTS-1:0]    req_i,
    output logic [NUM_PORTS-1:0]    gnt_o,
    input  logic [NUM_PORTS*32-1:0] addr_i,
    input  logic [NUM_PORTS-1:0]    we_i,
    input  logic [NUM_PORTS*4-1:0]  be_i,
    input  logic [NUM_PORTS*32-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]    rvalid_o,
    output logic [NUM_PORTS*32-1:0] rdata_o,
    output logic [NUM_PORTS-1:0]    err_o,
    output logic                    illegal_memory_o
);

    localparam int unsigned WORDS = SRAM_SIZE / 4;
    localparam int LAST = int'(READ_LATENCY) - 1;

    logic [31:0]           mem [WORDS];
    logic                  clearing;
    logic [NUM_PORTS-1:0]  acc;
    logic [NUM_PORTS-1:0]  bad;
    logic [NUM_PORTS-1:0]  wr;
    logic [ADDR_WIDTH-1:0] idx [NUM_PORTS];
    logic [31:0]           rd  [NUM_PORTS];

    logic                  v_q [NUM_PORTS][READ_LATENCY];
    logic                  e_q [NUM_PORTS][READ_LATENCY];
    logic [31:0]           d_q [NUM_PORTS][READ_LATENCY];

`ifdef FF_RAM_INIT_CLEAR_EN
    logic                  clr_q;
    logic [ADDR_WIDTH-1:0] clr_idx;

    // Sweep every word to zero after reset, restarting on any reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_q   <= 1'b1;
            clr_idx <= '0;
        end else if (clr_q) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == ADDR_WIDTH'(WORDS - 1))
                clr_q <= 1'b0;
        end
    end

    assign clearing = clr_q;
`else
    assign clearing = 1'b0;
`endif

    assign gnt_o = req_i & {NUM_PORTS{~clearing}};
    assign acc   = req_i & gnt_o;

    // Decode each port: window check via wrapped offset, error and read data.
    always_comb begin
        logic [31:0] off;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            off    = addr_i[p*32 +: 32] - SRAM_BASE_ADDR;
            idx[p] = off[ADDR_WIDTH+1:2];
            bad[p] = (off >= 32'(SRAM_SIZE))
                   || (we_i[p] && !PORT_WE_MASK[p]);
            wr[p]  = acc[p] & we_i[p] & ~bad[p];
            if (bad[p])
                rd[p] = 32'hDEADBEEF;
            else if (we_i[p])
                rd[p] = 32'h0;
            else
                rd[p] = mem[idx[p]];
        end
    end

    // Storage: highest port applied first so the lowest port wins a byte.
    always_ff @(posedge clk_i) begin
`ifdef FF_RAM_INIT_CLEAR_EN
        if (clearing)
            mem[clr_idx] <= 32'h0;
`endif
        for (int p = int'(NUM_PORTS) - 1; p >= 0; p--) begin
            if (wr[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[p*4 + b])
                        mem[idx[p]][b*8 +: 8] <= wdata_i[p*32 + b*8 +: 8];
                end
            end
        end
    end

    // Response shift pipeline; the output stage keeps data while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                for (int s = 0; s < int'(READ_LATENCY); s++) begin
                    v_q[p][s] <= 1'b0;
                    e_q[p][s] <= 1'b0;
                    d_q[p][s] <= 32'h0;
                end
            end
            illegal_memory_o <= 1'b0;
        end else begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                for (int s = LAST; s >= 1; s--) begin
                    v_q[p][s] <= v_q[p][s-1];
                    e_q[p][s] <= e_q[p][s-1];
                    if (s != LAST || v_q[p][s-1])
                        d_q[p][s] <= d_q[p][s-1];
                end
                v_q[p][0] <= acc[p];
                e_q[p][0] <= acc[p] & bad[p];
                if (LAST != 0 || acc[p])
                    d_q[p][0] <= rd[p];
            end
            illegal_memory_o <= |(acc & bad);
        end
    end

    // Present the final pipeline stage on the response ports.
    always_comb begin
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            rvalid_o[p]          = v_q[p][LAST];
            err_o[p]             = e_q[p][LAST];
            rdata_o[p*32 +: 32]  = d_q[p][LAST];
        end
    end

endmodule

// File: tb/tb_ff_ram_mp.sv
// Randomised self-checking bench for ff_ram_mp against a word-array model.
// Expected responses are queued per port with the edge at which they are due.
module tb_ff_ram_mp;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          SIZE  = 64;
    localparam int          NP    = 3;
    localparam int          LAT   = 2;
    localparam int          WORDS = SIZE / 4;
    localparam logic [NP-1:0] MASK = 3'b011;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   req = '0;
    logic [NP-1:0]   we = '0;
    logic [NP*32-1:0] addr = '0;
    logic [NP*32-1:0] wdata = '0;
    logic [NP*4-1:0] be = '0;
    logic [NP-1:0]   gnt;
    logic [NP-1:0]   rvalid;
    logic [NP-1:0]   err;
    logic [NP*32-1:0] rdata;
    logic            ill;

    ff_ram_mp #(
        .SRAM_BASE_ADDR (BASE),
        .SRAM_SIZE      (SIZE),
        .NUM_PORTS      (NP),
        .PORT_WE_MASK   (MASK),
        .READ_LATENCY   (LAT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .gnt_o            (gnt),
        .addr_i           (addr),
        .we_i             (we),
        .be_i             (be),
        .wdata_i          (wdata),
        .rvalid_o         (rvalid),
        .rdata_o          (rdata),
        .err_o            (err),
        .illegal_memory_o (ill)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        e;
        logic [31:0] d;
    } rsp_t;

    rsp_t        rq [NP][$];
    int          ill_q [$];
    logic [31:0] mm [WORDS];
    logic [31:0] last_d [NP];
    logic [31:0] cap_d [NP];
    logic        cap_e [NP];
    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic check_outs();
        for (int p = 0; p < NP; p++) begin
            logic ev;
            logic ee;
            ev = 1'b0;
            ee = 1'b0;
            if (rq[p].size() > 0 && rq[p][0].due == edge_n) begin
                ev = 1'b1;
                ee = rq[p][0].e;
                last_d[p] = rq[p][0].d;
                void'(rq[p].pop_front());
            end
            chk("rvalid", 32'(rvalid[p]), 32'(ev));
            chk("err", 32'(err[p]), 32'(ee));
            chk("rdata", rdata[p*32 +: 32], last_d[p]);
            if (rvalid[p]) begin
                cap_d[p] = rdata[p*32 +: 32];
                cap_e[p] = err[p];
            end
        end
        begin
            logic ei;
            ei = 1'b0;
            if (ill_q.size() > 0 && ill_q[0] == edge_n) begin
                ei = 1'b1;
                void'(ill_q.pop_front());
            end
            chk("illegal", 32'(ill), 32'(ei));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
        check_outs();
    endtask

    task automatic step(input logic [NP-1:0] v, input logic [NP*32-1:0] a,
                        input logic [NP-1:0] w, input logic [NP*4-1:0] b,
                        input logic [NP*32-1:0] wd);
        logic [31:0] nm [WORDS];
        logic [3:0]  taken [WORDS];
        bit          anyerr;
        req = v;
        addr = a;
        we = w;
        be = b;
        wdata = wd;
        #1;
        chk("gnt", 32'(gnt), 32'(v));
        nm = mm;
        foreach (taken[i]) taken[i] = 4'h0;
        anyerr = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (v[p]) begin
                logic [31:0] pa;
                logic        legal;
                logic        e;
                int          wi;
                rsp_t        r;
                pa = a[p*32 +: 32];
                legal = ({1'b0, pa} >= {1'b0, BASE})
                     && ({1'b0, pa} < {1'b0, BASE} + 33'(SIZE));
                e = !legal || (w[p] && !MASK[p]);
                wi = legal ? int'((pa - BASE) / 4) : 0;
                r.due = edge_n + LAT;
                r.e = e;
                r.d = e ? 32'hDEADBEEF : (w[p] ? 32'h0 : mm[wi]);
                rq[p].push_back(r);
                if (e) begin
                    anyerr = 1'b1;
                end else if (w[p]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (b[p*4 + k] && !taken[wi][k]) begin
                            nm[wi][k*8 +: 8] = wd[p*32 + k*8 +: 8];
                            taken[wi][k] = 1'b1;
                        end
                    end
                end
            end
        end
        if (anyerr)
            ill_q.push_back(edge_n + 1);
        tick();
        mm = nm;
    endtask

    task automatic one(input int p, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] wd);
        logic [NP-1:0]    v;
        logic [NP*32-1:0] av;
        logic [NP-1:0]    wv;
        logic [NP*4-1:0]  bv;
        logic [NP*32-1:0] dv;
        v = '0;
        av = '0;
        wv = '0;
        bv = '0;
        dv = '0;
        v[p] = 1'b1;
        av[p*32 +: 32] = a;
        wv[p] = w;
        bv[p*4 +: 4] = b;
        dv[p*32 +: 32] = wd;
        step(v, av, wv, bv, dv);
    endtask

    task automatic idle();
        step('0, '0, '0, '0, '0);
    endtask

    initial begin
        foreach (mm[i]) mm[i] = 32'h0;
        foreach (last_d[i]) last_d[i] = 32'h0;
        foreach (cap_d[i]) cap_d[i] = 32'h0;
        foreach (cap_e[i]) cap_e[i] = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rdata", rdata[31:0], 32'h0);
        chk("rst_ill", 32'(ill), 32'h0);
        rst = 1'b0;

`ifdef FF_RAM_INIT_CLEAR_EN
        req = '1;
        we = '0;
        addr = {NP{BASE}};
        for (int i = 0; i < WORDS; i++) begin
            #1;
            chk("sweep_gnt", 32'(gnt), 32'h0);
            tick();
        end
        for (int i = 0; i < WORDS; i++)
            one(0, BASE + 32'(i * 4), 1'b0, 4'h0, 32'h0);
        repeat (LAT) idle();
        chk("sweep_zero", cap_d[0], 32'h0);
`else
        for (int i = 0; i < WORDS; i++)
            one(0, BASE + 32'(i * 4), 1'b1, 4'hF, $urandom);
`endif

        one(0, BASE + 32'h4, 1'b1, 4'hF, 32'hCAFEF00D);
        one(1, BASE + 32'h4, 1'b0, 4'h0, 32'h0);
        repeat (LAT) idle();
        chk("t1_data", cap_d[1], 32'hCAFEF00D);

        one(0, BASE + 32'hC, 1'b1, 4'hF, 32'hAAAAAAAA);
        one(0, BASE + 32'hC, 1'b1, 4'b0101, 32'h11223344);
        one(1, BASE + 32'hC, 1'b0, 4'h0, 32'h0);
        repeat (LAT) idle();
        chk("t2_merge", cap_d[1], 32'hAA22AA44);

        one(0, BASE + 32'h8, 1'b1, 4'hF, 32'h0);
        step(3'b011, {32'h0, BASE + 32'h8, BASE + 32'h8}, 3'b011,
             {4'h0, 4'h3, 4'h1}, {32'h0, 32'h0000EE00, 32'h000000FF});
        one(2, BASE + 32'h8, 1'b0, 4'h0, 32'h0);
        repeat (LAT) idle();
        chk("t3_conflict", cap_d[2], 32'h0000EEFF);

        one(2, BASE, 1'b1, 4'hF, 32'h12345678);
        repeat (LAT) idle();
        chk("t4_ro_data", cap_d[2], 32'hDEADBEEF);
        chk("t4_ro_err", 32'(cap_e[2]), 32'h1);
        one(0, BASE + 32'(SIZE), 1'b0, 4'h0, 32'h0);
        repeat (LAT) idle();
        chk("t4_oob_data", cap_d[0], 32'hDEADBEEF);
        chk("t4_oob_err", 32'(cap_e[0]), 32'h1);
        one(1, BASE, 1'b0, 4'h0, 32'h0);
        one(1, BASE - 32'h1, 1'b0, 4'h0, 32'h0);
        repeat (LAT) idle();

        for (int i = 0; i < 300; i++) begin
            logic [NP*32-1:0] av;
            for (int p = 0; p < NP; p++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 8)
                    av[p*32 +: 32] = BASE + 32'($urandom_range(0, SIZE - 1));
                else if (r == 8)
                    av[p*32 +: 32] = BASE + 32'(SIZE) + 32'($urandom_range(0, 3));
                else
                    av[p*32 +: 32] = BASE - 32'($urandom_range(1, 4));
            end
            step(NP'($urandom), av, NP'($urandom), (NP*4)'($urandom),
                 {$urandom, $urandom, $urandom});
        end
        repeat (LAT) idle();

        one(0, BASE, 1'b0, 4'h0, 32'h0);
        one(0, BASE + 32'h4, 1'b0, 4'h0, 32'h0);
        req = 3'b001;
        addr = '0;
        addr[31:0] = BASE + 32'h8;
        we = '0;
        rst = 1'b1;
        #1;
        for (int p = 0; p < NP; p++) rq[p].delete();
        ill_q.delete();
        foreach (last_d[i]) last_d[i] = 32'h0;
        check_outs();
        @(posedge clk);
        edge_n++;
        #1;
        req = '0;
        check_outs();
        rst = 1'b0;
        repeat (LAT + 2) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
